// File: rtl/inst_rom_resp.sv
// Fetch-side instruction memory responder: answers (addr, ce) fetches after LATENCY cycles,
// returning NOP_WORD with addr_err for misaligned or out-of-range addresses.
module inst_rom_resp #(
    parameter int          DEPTH_LOG2 = 10,
    parameter int          LATENCY    = 2,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic [31:0]           addr,
    output logic [31:0]           inst,
    output logic                  inst_valid,
    output logic                  addr_err,
    output logic                  ready,
    input  logic                  load_en,
    input  logic [DEPTH_LOG2-1:0] load_addr,
    input  logic [31:0]           load_data
);

    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $error("inst_rom_resp: LATENCY must be in 1..4");
    end

    logic [31:0] r_mem [0:(1<<DEPTH_LOG2)-1];

    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_err;
    logic                  w_acc;
    logic [31:0]           w_rd_data;

    assign w_idx     = addr[DEPTH_LOG2+1:2];
    assign w_err     = (|addr[1:0]) | (|addr[31:DEPTH_LOG2+2]);
    assign w_acc     = ce & ~load_en;
    assign w_rd_data = w_err ? NOP_WORD : r_mem[w_idx];
    assign ready     = ~load_en;

    // Array contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (load_en) begin
            r_mem[load_addr] <= load_data;
        end
    end

    for (genvar s = 0; s < LATENCY; s++) begin : g_stage
        logic        w_in_vld;
        logic        w_in_err;
        logic [31:0] w_in_data;
        logic        r_vld;
        logic        r_err;
        logic [31:0] r_data;

        if (s == 0) begin : g_first
            assign w_in_vld  = w_acc;
            assign w_in_err  = w_err;
            assign w_in_data = w_rd_data;
        end else begin : g_next
            assign w_in_vld  = g_stage[s-1].r_vld;
            assign w_in_err  = g_stage[s-1].r_err;
            assign w_in_data = g_stage[s-1].r_data;
        end

        if (s == LATENCY - 1) begin : g_out
            // Output stage only loads on a valid beat so inst holds through gaps.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_vld  <= 1'b0;
                    r_err  <= 1'b0;
                    r_data <= 32'h0;
                end else begin
                    r_vld <= w_in_vld;
                    if (w_in_vld) begin
                        r_err  <= w_in_err;
                        r_data <= w_in_data;
                    end
                end
            end
        end else begin : g_mid
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_vld <= 1'b0;
                end else begin
                    r_vld <= w_in_vld;
                end
            end

            always_ff @(posedge clk) begin
                r_err  <= w_in_err;
                r_data <= w_in_data;
            end
        end
    end

    assign inst       = g_stage[LATENCY-1].r_data;
    assign inst_valid = g_stage[LATENCY-1].r_vld;
    assign addr_err   = g_stage[LATENCY-1].r_vld & g_stage[LATENCY-1].r_err;

endmodule

// File: tb/tb_inst_rom_resp.sv
// Scoreboard bench for inst_rom_resp: one LATENCY=2 and one LATENCY=3 instance share stimulus.
module tb_inst_rom_resp;

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        ce;
    logic [31:0] addr;
    logic        load_en;
    logic [9:0]  load_addr;
    logic [31:0] load_data;

    logic [31:0] inst_a, inst_b;
    logic        inst_valid_a, inst_valid_b;
    logic        addr_err_a, addr_err_b;
    logic        ready_a, ready_b;

    exp_t        qa[$];
    exp_t        qb[$];
    logic [31:0] mem_m [0:1023];
    logic [31:0] last_a, last_b;
    int          cyc;
    int          checks;
    int          errors;

    inst_rom_resp #(.DEPTH_LOG2(10), .LATENCY(2), .NOP_WORD(32'h0)) u_a (
        .clk(clk), .rst(rst), .ce(ce), .addr(addr),
        .inst(inst_a), .inst_valid(inst_valid_a), .addr_err(addr_err_a), .ready(ready_a),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    inst_rom_resp #(.DEPTH_LOG2(10), .LATENCY(3), .NOP_WORD(32'h0)) u_b (
        .clk(clk), .rst(rst), .ce(ce), .addr(addr),
        .inst(inst_b), .inst_valid(inst_valid_b), .addr_err(addr_err_b), .ready(ready_b),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pop_front(input int id);
        if (id == 0) void'(qa.pop_front());
        else         void'(qb.pop_front());
    endtask

    task automatic mon(input int id, input logic v, input logic [31:0] d, input logic e);
        exp_t        x;
        int          n;
        logic [31:0] lst;
        string       p;
        p   = (id == 0) ? "A" : "B";
        n   = (id == 0) ? qa.size() : qb.size();
        lst = (id == 0) ? last_a : last_b;
        if (n > 0) begin
            if (id == 0) x = qa[0];
            else         x = qb[0];
        end
        if (v) begin
            if (n == 0) begin
                check({p, "_spurious_valid"}, {31'b0, v}, 32'h0);
            end else begin
                pop_front(id);
                check({p, "_latency"}, 32'(cyc), 32'(x.due));
                check({p, "_inst"}, d, x.data);
                check({p, "_addr_err"}, {31'b0, e}, {31'b0, x.err});
                if (id == 0) last_a = d;
                else         last_b = d;
            end
        end else begin
            check({p, "_idle_err"}, {31'b0, e}, 32'h0);
            check({p, "_hold"}, d, lst);
            if (n > 0 && x.due <= cyc) begin
                check({p, "_missing_valid"}, {31'b0, v}, 32'h1);
                pop_front(id);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, inst_valid_a, inst_a, addr_err_a);
        mon(1, inst_valid_b, inst_b, addr_err_b);
    end

    task automatic step(input logic c, input logic [31:0] a, input logic le,
                        input logic [9:0] la, input logic [31:0] ld);
        exp_t x;
        @(negedge clk);
        ce        = c;
        addr      = a;
        load_en   = le;
        load_addr = la;
        load_data = ld;
        if (c && !le) begin
            x.err  = (a[1:0] != 2'b00) || (a[31:12] != 20'h0);
            x.data = x.err ? 32'h0 : mem_m[a[11:2]];
            x.due  = cyc + 2;
            qa.push_back(x);
            x.due  = cyc + 3;
            qb.push_back(x);
        end
        if (le) mem_m[la] = ld;
        #1;
        check("ready_a", {31'b0, ready_a}, {31'b0, ~le});
        check("ready_b", {31'b0, ready_b}, {31'b0, ~le});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid_a"}, {31'b0, inst_valid_a}, 32'h0);
        check({tag, "_inst_a"},  inst_a, 32'h0);
        check({tag, "_err_a"},   {31'b0, addr_err_a}, 32'h0);
        check({tag, "_valid_b"}, {31'b0, inst_valid_b}, 32'h0);
        check({tag, "_inst_b"},  inst_b, 32'h0);
        check({tag, "_err_b"},   {31'b0, addr_err_b}, 32'h0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        last_a    = 32'h0;
        last_b    = 32'h0;
        rst       = 1'b1;
        ce        = 1'b0;
        addr      = 32'h0;
        load_en   = 1'b0;
        load_addr = 10'h0;
        load_data = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        #1 rst = 1'b0;

        // Preload and sequential fetches
        step(1'b0, 32'h0, 1'b1, 10'd0, 32'h34011100);
        step(1'b0, 32'h0, 1'b1, 10'd1, 32'h34020020);
        step(1'b0, 32'h0, 1'b1, 10'd2, 32'h34030F00);
        step(1'b1, 32'h0, 1'b0, 10'd0, 32'h0);
        step(1'b1, 32'h4, 1'b0, 10'd0, 32'h0);
        step(1'b1, 32'h8, 1'b0, 10'd0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 10'd0, 32'h0);

        // Address errors
        step(1'b1, 32'h0000_0006, 1'b0, 10'd0, 32'h0);
        step(1'b1, 32'h0000_1000, 1'b0, 10'd0, 32'h0);
        step(1'b1, 32'h8000_0000, 1'b0, 10'd0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 10'd0, 32'h0);

        // Load collides with fetch: fetch dropped, then refetch sees new word
        step(1'b1, 32'h4, 1'b1, 10'd1, 32'hDEADBEEF);
        step(1'b1, 32'h4, 1'b0, 10'd0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 10'd0, 32'h0);

        // Read then write: in-flight read keeps old word
        step(1'b1, 32'h8, 1'b0, 10'd0, 32'h0);
        step(1'b0, 32'h0, 1'b1, 10'd2, 32'h11111111);
        step(1'b1, 32'h8, 1'b0, 10'd0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 10'd0, 32'h0);

        // Gaps in ce; back-to-back same address
        step(1'b1, 32'h0, 1'b0, 10'd0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 10'd0, 32'h0);
        step(1'b1, 32'h4, 1'b0, 10'd0, 32'h0);
        step(1'b1, 32'h4, 1'b0, 10'd0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 10'd0, 32'h0);
        repeat (4) step(1'b0, 32'h0, 1'b0, 10'd0, 32'h0);

        // Asynchronous reset with requests in flight
        step(1'b1, 32'h0, 1'b0, 10'd0, 32'h0);
        step(1'b1, 32'h4, 1'b0, 10'd0, 32'h0);
        @(posedge clk);
        #2;
        rst    = 1'b1;
        ce     = 1'b0;
        qa.delete();
        qb.delete();
        last_a = 32'h0;
        last_b = 32'h0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        #1 rst = 1'b0;
        step(1'b0, 32'h0, 1'b0, 10'd0, 32'h0);
        step(1'b1, 32'h8, 1'b0, 10'd0, 32'h0);
        step(1'b1, 32'h0, 1'b0, 10'd0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 10'd0, 32'h0);

        for (int i = 0; i < 20 && (qa.size() + qb.size()) > 0; i++) @(negedge clk);
        check("drain_pending", 32'(qa.size() + qb.size()), 32'h0);
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_rom_resp.md
Name: inst_rom_resp

Overview:
Instruction-memory responder on the fetch side of the CPU. It answers the fetch stage's (pc, ce) requests with 32-bit instruction words after a fixed pipelined latency, and flags misaligned or out-of-range addresses. A load port preloads program contents before or between runs.

Parameters:
DEPTH_LOG2, 10, log2 of word count (default 1024 words = 4 KiB).
LATENCY, 2, cycles from accepted request to inst_valid; legal range 1..4.
NOP_WORD, 32'h00000000, instruction returned on an address error.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous reset, active-high
ce  in  1  fetch enable (chip enable) from PC register
addr  in  32  byte address of instruction (pc)
inst  out  32  returned instruction word
inst_valid  out  1  inst/addr_err valid this cycle
addr_err  out  1  request was misaligned or out of range
ready  out  1  combinational: 1 when a fetch can be accepted (= ~load_en)
load_en  in  1  write one word into the array this cycle
load_addr  in  DEPTH_LOG2  word index for load
load_data  in  32  word to write

Behaviour:
- Reset: one clk, asynchronous active-high rst; all reset asynchronous. inst=32'h0, inst_valid=0, addr_err=0, all pipeline valid bits=0; in-flight requests discarded. Memory array is NOT reset (contents survive rst).
- Accept: request accepted on a rising edge when ce=1 and load_en=0. ce=1 with load_en=1: load wins, the fetch is dropped silently (no inst_valid for it); the fetcher sees ready=0.
- Decode: word index = addr[DEPTH_LOG2+1:2]. Error if addr[1:0]!=0 (misaligned) or any addr[31:DEPTH_LOG2+2] bit set (out of range). Error request returns inst=NOP_WORD, addr_err=1; array not read.
- Read: array read at the acceptance edge (stage 1); data captured then, so later loads do not alter in-flight data. Stages 2..LATENCY are pure delay registers carrying {valid, err, data}.
- Latency: request accepted at edge N -> inst_valid=1, inst, addr_err presented after edge N+LATENCY-1... i.e. exactly LATENCY cycles after the cycle ce was sampled high. Fully pipelined: one request per cycle sustained, results in request order.
- Idle: when output stage not valid, inst_valid=0, addr_err=0, inst holds last delivered value.
- Load: on edge with load_en=1, mem[load_addr] <= load_data. Load to an address being read by an earlier accepted request does not affect that request (read already captured).
- Back-to-back same address: each request returns its own copy; no merging.
- rst asserted mid-stream: outputs drop to reset values immediately (asynchronous); after release first inst_valid appears LATENCY cycles after the first accepted request.
- LATENCY outside 1..4: elaboration error.

Test Plan:
1. Reset: assert rst mid-cycle with two requests in flight -> inst_valid=0, inst=0, addr_err=0 immediately; no stale valid after release.
2. Preload mem[0]=32'h34011100, mem[1]=32'h34020020, mem[2]=32'h34030F00; ce=1 with addr 0x0,0x4,0x8 on consecutive cycles (LATENCY=2) -> inst_valid high 3 consecutive cycles starting 2 cycles after first request, inst 34011100, 34020020, 34030F00, addr_err=0.
3. Misaligned addr 0x00000006 and out-of-range 0x00001000 (DEPTH_LOG2=10) -> each returns inst=00000000, addr_err=1, inst_valid=1 at LATENCY.
4. Collision: ce=1 addr 0x4 with load_en=1 load_addr=1 load_data=0xDEADBEEF same cycle -> ready=0, no inst_valid for that slot; next-cycle fetch of 0x4 returns DEADBEEF.
5. Read-then-write: fetch 0x8 at cycle N, load mem[2]=0x11111111 at N+1 -> response at N+2 is 34030F00; fresh fetch returns 11111111.
6. Gaps: ce toggling 1,0,1 with LATENCY=3 -> inst_valid pattern 1,0,1 shifted by 3 cycles; inst holds value during gap.
